regfile_writeback: RTL and testbench

Write-port owner for the pipelined core's three-ported register file. Merges single-cycle results from the W stage with results from long-latency units (multiplier/divider) into the file's one write port (we3/a3/wd3). Keeps a scoreboard of destinations still pending from long-latency units, for the hazard unit. Guarantees long-latency results are not starved by back-to-back pipeline writes.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 48 ++++
 rtl/regfile_writeback.sv | 132 +++++++++++++
 tb/tb_regfile_writeback.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback port.
// Holds data width, register address width and the queued slow-result entry.
package wb_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of long-latency writeback entries.
// Ports: clk, reset (async high), push/din, pop, head (oldest entry), count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  wb_entry_t     din,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage needs no reset: count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/regfile_writeback.sv
// Owner of the register file write port: merges W-stage and slow results.
// Ports: pipe_* (W stage, stall), slow_* (FIFO in), iss_* (scoreboard set),
//        q1/q2 -> busy1/busy2, we3/a3/wd3 (regfile), fifo_count.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int CW          = $clog2(DEPTH) + 1,
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_valid,
    input  logic [4:0]       pipe_rd,
    input  logic [XLEN-1:0]  pipe_wd,
    output logic             pipe_stall,
    input  logic             slow_valid,
    output logic             slow_ready,
    input  logic [4:0]       slow_rd,
    input  logic [XLEN-1:0]  slow_wd,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    input  logic [4:0]       q1,
    input  logic [4:0]       q2,
    output logic             busy1,
    output logic             busy2,
    output logic             we3,
    output logic [4:0]       a3,
    output logic [XLEN-1:0]  wd3,
    output logic [CW-1:0]    fifo_count
);

    wb_entry_t   head;
    wb_entry_t   din;
    logic        push;
    logic        pop;
    logic        empty;
    logic        head_slot;
    logic        pipe_slot;
    logic        pipe_live;
    logic [SW-1:0] starve;
    logic [31:0] sb;
    logic [31:0] sb_next;

    assign din.rd = slow_rd;
    assign din.wd = slow_wd;

    assign slow_ready = (fifo_count < CW'(DEPTH));
    assign push       = slow_valid && slow_ready;
    assign empty      = (fifo_count == '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .count (fifo_count)
    );

    // A pipe result to x0 is a no-op, so the head may take its slot.
    assign pipe_live  = pipe_valid && (pipe_rd != 5'd0);
    assign pipe_stall = pipe_live && !empty &&
                        (starve == SW'(STARVE_LIMIT));
    assign head_slot  = !empty && (pipe_stall || !pipe_live);
    assign pipe_slot  = !head_slot && pipe_valid;
    assign pop        = head_slot;

    always_comb begin
        we3 = 1'b0;
        a3  = '0;
        wd3 = '0;
        unique case (1'b1)
            head_slot: begin
                we3 = (head.rd != 5'd0);
                a3  = head.rd;
                wd3 = head.wd;
            end
            pipe_slot: begin
                we3 = (pipe_rd != 5'd0);
                a3  = pipe_rd;
                wd3 = pipe_wd;
            end
            default: begin
            end
        endcase
    end

    // At the limit the head is always popped, so no saturation needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve <= '0;
        end else if (empty || pop) begin
            starve <= '0;
        end else begin
            starve <= starve + SW'(1);
        end
    end

    // Clear first, then set, so a same-cycle set on that register wins.
    always_comb begin
        sb_next = sb;
        if (pop && head.rd != 5'd0) begin
            sb_next[head.rd] = 1'b0;
        end
        if (iss_valid && iss_rd != 5'd0) begin
            sb_next[iss_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // A register being written this cycle reads as ready: the regfile
    // commits on the falling edge before the reader samples it.
    assign busy1 = (q1 != 5'd0) && sb[q1] &&
                   !(head_slot && we3 && a3 == q1);
    assign busy2 = (q2 != 5'd0) && sb[q2] &&
                   !(head_slot && we3 && a3 == q2);

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback.
// Expected regfile writes are queued as stimulus is driven and compared on writes.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        pipe_stall;
    logic        slow_valid;
    logic        slow_ready;
    logic [4:0]  slow_rd;
    logic [31:0] slow_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        busy1;
    logic        busy2;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [1:0]  fifo_count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] rf [32];
    int          checks   = 0;
    int          failures = 0;

    regfile_writeback #(
        .XLEN         (32),
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_wd    (pipe_wd),
        .pipe_stall (pipe_stall),
        .slow_valid (slow_valid),
        .slow_ready (slow_ready),
        .slow_rd    (slow_rd),
        .slow_wd    (slow_wd),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .q1         (q1),
        .q2         (q2),
        .busy1      (busy1),
        .busy2      (busy2),
        .we3        (we3),
        .a3         (a3),
        .wd3        (wd3),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
        exp_t e;
        e.rd = rd;
        e.wd = wd;
        expq.push_back(e);
    endtask

    // Regfile model commits on the falling edge, like the real array.
    always @(negedge clk) begin
        if (!reset && we3) begin
            if (expq.size() == 0) begin
                chk("wr_unexpected", {27'd0, a3}, 64'hFFFF);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("wr_a3", {59'd0, a3}, {59'd0, e.rd});
                chk("wr_wd3", {32'd0, wd3}, {32'd0, e.wd});
            end
            rf[a3] = wd3;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset      = 1'b1;
        pipe_valid = 1'b0;
        pipe_rd    = '0;
        pipe_wd    = '0;
        slow_valid = 1'b0;
        slow_rd    = '0;
        slow_wd    = '0;
        iss_valid  = 1'b0;
        iss_rd     = '0;
        q1         = 5'd7;
        q2         = 5'd9;

        // Reset values
        #12;
        chk("rst_we3", {63'd0, we3}, 64'd0);
        chk("rst_a3", {59'd0, a3}, 64'd0);
        chk("rst_wd3", {32'd0, wd3}, 64'd0);
        chk("rst_stall", {63'd0, pipe_stall}, 64'd0);
        chk("rst_ready", {63'd0, slow_ready}, 64'd1);
        chk("rst_busy1", {63'd0, busy1}, 64'd0);
        chk("rst_count", {62'd0, fifo_count}, 64'd0);
        reset = 1'b0;
        tick();

        // Pipe only: zero-latency write
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'h0000_1234;
        expect_wr(5'd5, 32'h0000_1234);
        settle();
        chk("pipe_we3", {63'd0, we3}, 64'd1);
        chk("pipe_a3", {59'd0, a3}, 64'd5);
        tick();
        pipe_valid = 1'b0;
        settle();
        chk("pipe_rf5", {32'd0, rf[5]}, 64'h1234);

        // Slow path with scoreboard
        iss_valid = 1'b1; iss_rd = 5'd7;
        settle();
        chk("iss_busy_now", {63'd0, busy1}, 64'd0);
        tick();
        iss_valid = 1'b0;
        settle();
        chk("iss_busy_next", {63'd0, busy1}, 64'd1);
        tick();
        slow_valid = 1'b1; slow_rd = 5'd7; slow_wd = 32'hDEAD_BEEF;
        expect_wr(5'd7, 32'hDEAD_BEEF);
        settle();
        chk("slow_push_we3", {63'd0, we3}, 64'd0);
        chk("slow_push_busy", {63'd0, busy1}, 64'd1);
        tick();
        slow_valid = 1'b0;
        settle();
        chk("slow_we3", {63'd0, we3}, 64'd1);
        chk("slow_a3", {59'd0, a3}, 64'd7);
        chk("slow_busy_pop", {63'd0, busy1}, 64'd0);
        tick();
        settle();
        chk("slow_busy_after", {63'd0, busy1}, 64'd0);
        chk("slow_count_after", {62'd0, fifo_count}, 64'd0);
        chk("slow_rf7", {32'd0, rf[7]}, 64'hDEAD_BEEF);

        // Starvation: head rd=9 under continuous pipe writes to x3
        iss_valid = 1'b1; iss_rd = 5'd9;
        slow_valid = 1'b1; slow_rd = 5'd9; slow_wd = 32'h0000_0099;
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h300;
        expect_wr(5'd3, 32'h300);
        tick();
        iss_valid = 1'b0;
        slow_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pipe_wd = 32'h300 + i;
            expect_wr(5'd3, pipe_wd);
            settle();
            chk($sformatf("starve_wait%0d", i), {63'd0, pipe_stall}, 64'd0);
            chk($sformatf("starve_busy%0d", i), {63'd0, busy2}, 64'd1);
            tick();
        end
        pipe_wd = 32'h305;
        expect_wr(5'd9, 32'h99);
        settle();
        chk("starve_stall", {63'd0, pipe_stall}, 64'd1);
        chk("starve_a3", {59'd0, a3}, 64'd9);
        chk("starve_busy_pop", {63'd0, busy2}, 64'd0);
        tick();
        expect_wr(5'd3, 32'h305);
        settle();
        chk("held_stall", {63'd0, pipe_stall}, 64'd0);
        chk("held_a3", {59'd0, a3}, 64'd3);
        chk("held_wd3", {32'd0, wd3}, 64'h305);
        tick();

        // Backpressure and x0
        pipe_rd = 5'd4; pipe_wd = 32'h400;
        slow_valid = 1'b1; slow_rd = 5'd10; slow_wd = 32'hA0;
        expect_wr(5'd4, 32'h400);
        tick();
        pipe_wd = 32'h401;
        slow_rd = 5'd0; slow_wd = 32'hB0;
        expect_wr(5'd4, 32'h401);
        tick();
        slow_rd = 5'd11; slow_wd = 32'hC0;
        pipe_rd = 5'd0; pipe_wd = 32'h555;
        expect_wr(5'd10, 32'hA0);
        settle();
        chk("bp_ready", {63'd0, slow_ready}, 64'd0);
        chk("bp_count", {62'd0, fifo_count}, 64'd2);
        chk("x0_head_we3", {63'd0, we3}, 64'd1);
        chk("x0_head_a3", {59'd0, a3}, 64'd10);
        tick();
        slow_valid = 1'b0;
        pipe_valid = 1'b0;
        settle();
        chk("x0_entry_count", {62'd0, fifo_count}, 64'd1);
        chk("x0_entry_we3", {63'd0, we3}, 64'd0);
        tick();
        settle();
        chk("x0_drained", {62'd0, fifo_count}, 64'd0);
        chk("x0_ready", {63'd0, slow_ready}, 64'd1);

        // Set/clear collision on x7
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        slow_valid = 1'b1; slow_rd = 5'd7; slow_wd = 32'h77;
        tick();
        slow_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        expect_wr(5'd7, 32'h77);
        settle();
        chk("coll_a3", {59'd0, a3}, 64'd7);
        tick();
        iss_valid = 1'b0;
        settle();
        chk("coll_busy", {63'd0, busy1}, 64'd1);

        // Reset mid-operation with two entries queued and sb[7] set
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h600;
        slow_valid = 1'b1; slow_rd = 5'd12; slow_wd = 32'hC12;
        expect_wr(5'd3, 32'h600);
        tick();
        pipe_wd = 32'h601;
        slow_rd = 5'd13; slow_wd = 32'hC13;
        expect_wr(5'd3, 32'h601);
        tick();
        slow_valid = 1'b0;
        pipe_wd = 32'h602;
        expect_wr(5'd3, 32'h602);
        settle();
        chk("pre_rst_count", {62'd0, fifo_count}, 64'd2);
        chk("pre_rst_busy", {63'd0, busy1}, 64'd1);
        #3;
        reset = 1'b1;
        pipe_valid = 1'b0;
        #1;
        chk("mid_rst_we3", {63'd0, we3}, 64'd0);
        chk("mid_rst_a3", {59'd0, a3}, 64'd0);
        chk("mid_rst_wd3", {32'd0, wd3}, 64'd0);
        chk("mid_rst_count", {62'd0, fifo_count}, 64'd0);
        chk("mid_rst_ready", {63'd0, slow_ready}, 64'd1);
        chk("mid_rst_busy", {63'd0, busy1}, 64'd0);
        chk("mid_rst_stall", {63'd0, pipe_stall}, 64'd0);
        #5;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        settle();
        chk("post_rst_count", {62'd0, fifo_count}, 64'd0);
        chk("post_rst_busy", {63'd0, busy1}, 64'd0);
        chk("exp_queue_empty", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
